// File: rtl/fabric_pe_pkg.sv
// fabric_pe_pkg: shared tag modes, width helper and error codes for fabric PEs
package fabric_pe_pkg;
    typedef enum logic {
        TAG_OVERWRITE   = 1'b0,
        TAG_TRANSPARENT = 1'b1
    } pe_tag_mode_e;
    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_TAG_MISMATCH = 2'd1;
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fabric_fifo_sync.sv
// fabric_fifo_sync: circular FIFO with combinational head and async active-low reset
module fabric_fifo_sync
    import fabric_pe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = safe_clog2(DEPTH);
    localparam int CW = safe_clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/fabric_pe_store_buffered.sv
// fabric_pe_store_buffered: queued store adapter issuing synchronized addr/data stores and returning done tags
module fabric_pe_store_buffered
    import fabric_pe_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 0,
    parameter int HW_TYPE         = 0,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int PW     = DATA_WIDTH + TAG_WIDTH,
    localparam int TW     = (TAG_WIDTH > 0) ? TAG_WIDTH : 1,
    localparam int CFG_W  = (HW_TYPE == 0 && TAG_WIDTH > 0) ? TAG_WIDTH : 0,
    localparam int CFG_W1 = (CFG_W > 0) ? CFG_W : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [PW-1:0]     in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [PW-1:0]     in1_data,
    input  logic              in2_valid,
    output logic              in2_ready,
    input  logic [PW-1:0]     in2_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [PW-1:0]     out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [PW-1:0]     out1_data,
    input  logic              mem_done_valid,
    output logic              mem_done_ready,
    output logic              out2_valid,
    input  logic              out2_ready,
    output logic [TW-1:0]     out2_data,
    output logic              err_tag_mismatch,
    input  logic [CFG_W1-1:0] cfg_data
);
    localparam pe_tag_mode_e MODE = (HW_TYPE == 1) ? TAG_TRANSPARENT : TAG_OVERWRITE;
    localparam int CNT_W = safe_clog2(MAX_OUTSTANDING + 1);
    if (DATA_WIDTH < 1 || TAG_WIDTH < 0 || (HW_TYPE != 0 && HW_TYPE != 1) ||
        (HW_TYPE == 1 && TAG_WIDTH == 0) || QUEUE_DEPTH < 2 || MAX_OUTSTANDING < 1) begin : g_param_check
        $fatal(1, "fabric_pe_store_buffered: illegal parameter combination");
    end
    logic [2:0] in_valid, full, empty;
    logic [PW-1:0] in_data [3];
    logic [PW-1:0] head [3];
    logic [TW-1:0] addr_tag, data_tag, ctrl_tag, st_tag, pend_tag;
    logic [CNT_W-1:0] count;
    logic tags_match, issue, fire, done, pend_full, pend_empty;
    logic unused;
    assign in_valid   = {in2_valid, in1_valid, in0_valid};
    assign in_data[0] = in0_data;
    assign in_data[1] = in1_data;
    assign in_data[2] = in2_data;
    assign {in2_ready, in1_ready, in0_ready} = ~full;
    for (genvar i = 0; i < 3; i++) begin : g_q
        fabric_fifo_sync #(.WIDTH(PW), .DEPTH(QUEUE_DEPTH)) u_q (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[i]),
            .pop   (fire),
            .din   (in_data[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end
    if (TAG_WIDTH > 0) begin : g_tagged
        assign addr_tag  = head[0][PW-1 -: TW];
        assign data_tag  = head[1][PW-1 -: TW];
        assign ctrl_tag  = head[2][TW-1:0];
        assign out0_data = {st_tag, head[0][DATA_WIDTH-1:0]};
        assign out1_data = {st_tag, head[1][DATA_WIDTH-1:0]};
    end else begin : g_untagged
        assign addr_tag  = '0;
        assign data_tag  = '0;
        assign ctrl_tag  = '0;
        assign out0_data = head[0];
        assign out1_data = head[1];
    end
    if (CFG_W > 0) begin : g_cfg_tag
        assign st_tag = TW'(cfg_data);
    end else if (MODE == TAG_TRANSPARENT) begin : g_pass_tag
        assign st_tag = addr_tag;
    end else begin : g_zero_tag
        assign st_tag = '0;
    end
    assign tags_match     = (MODE == TAG_OVERWRITE) || (addr_tag == data_tag && data_tag == ctrl_tag);
    assign issue          = ~|empty && tags_match && count < CNT_W'(MAX_OUTSTANDING);
    assign out0_valid     = issue && out1_ready;
    assign out1_valid     = issue && out0_ready;
    assign fire           = issue && out0_ready && out1_ready;
    assign out2_valid     = mem_done_valid && count != '0;
    assign mem_done_ready = out2_ready && count != '0;
    assign done           = out2_valid && out2_ready;
    assign out2_data      = pend_tag;
    assign unused         = ^{cfg_data, head[2], addr_tag, data_tag, ctrl_tag, st_tag, pend_full, pend_empty};
    fabric_fifo_sync #(.WIDTH(TW), .DEPTH(MAX_OUTSTANDING)) u_pend (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire),
        .pop   (done),
        .din   (st_tag),
        .full  (pend_full),
        .empty (pend_empty),
        .head  (pend_tag)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count            <= '0;
            err_tag_mismatch <= 1'b0;
        end else begin
            count <= count + CNT_W'(fire) - CNT_W'(done);
            if (MODE == TAG_TRANSPARENT && &full && !tags_match) err_tag_mismatch <= 1'b1;
        end
endmodule

// File: tb/tb_fabric_pe_store_buffered.sv
// tb_fabric_pe_store_buffered: queue-model checks of an overwrite instance plus directed transparent-mode checks
module tb_fabric_pe_store_buffered;
    localparam int PW = 36;
    localparam int QD = 4;
    localparam int MO = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic [2:0] iv, ir;
    logic [PW-1:0] id0, id1, id2, o0d, o1d;
    logic o0v, o0r, o1v, o1r, mdv, mdr, o2v, o2r, err;
    logic [3:0] o2d, cfg;
    logic [2:0] bv, br;
    logic [PW-1:0] bd0, bd1, bd2, b0d, b1d;
    logic b0v, b0r, b1v, b1r, bmdv, bmdr, b2v, b2r, berr, bcfg;
    logic [3:0] b2d;
    int n_cmp = 0;
    int n_bad = 0;
    logic [PW-1:0] mq0[$], mq1[$], mq2[$];
    logic [3:0] mp[$];

    fabric_pe_store_buffered #(.DATA_WIDTH(32), .TAG_WIDTH(4), .HW_TYPE(0), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) u_ovr (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(iv[0]), .in0_ready(ir[0]), .in0_data(id0),
        .in1_valid(iv[1]), .in1_ready(ir[1]), .in1_data(id1),
        .in2_valid(iv[2]), .in2_ready(ir[2]), .in2_data(id2),
        .out0_valid(o0v), .out0_ready(o0r), .out0_data(o0d),
        .out1_valid(o1v), .out1_ready(o1r), .out1_data(o1d),
        .mem_done_valid(mdv), .mem_done_ready(mdr),
        .out2_valid(o2v), .out2_ready(o2r), .out2_data(o2d),
        .err_tag_mismatch(err), .cfg_data(cfg)
    );

    fabric_pe_store_buffered #(.DATA_WIDTH(32), .TAG_WIDTH(4), .HW_TYPE(1), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(8)) u_trn (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(bv[0]), .in0_ready(br[0]), .in0_data(bd0),
        .in1_valid(bv[1]), .in1_ready(br[1]), .in1_data(bd1),
        .in2_valid(bv[2]), .in2_ready(br[2]), .in2_data(bd2),
        .out0_valid(b0v), .out0_ready(b0r), .out0_data(b0d),
        .out1_valid(b1v), .out1_ready(b1r), .out1_data(b1d),
        .mem_done_valid(bmdv), .mem_done_ready(bmdr),
        .out2_valid(b2v), .out2_ready(b2r), .out2_data(b2d),
        .err_tag_mismatch(berr), .cfg_data(bcfg)
    );

    function automatic bit m_issue();
        return mq0.size() > 0 && mq1.size() > 0 && mq2.size() > 0 && mp.size() < MO;
    endfunction

    function automatic logic [2:0] m_ready();
        return {mq2.size() < QD, mq1.size() < QD, mq0.size() < QD};
    endfunction

    task automatic clear_model();
        mq0.delete();
        mq1.delete();
        mq2.delete();
        mp.delete();
    endtask

    task automatic step_a();
        bit f, d, p0, p1, p2;
        logic [PW-1:0] d0, d1, d2;
        logic [3:0] t;
        f = m_issue() && o0r && o1r;
        d = mdv && o2r && mp.size() > 0;
        p0 = iv[0] && mq0.size() < QD;
        p1 = iv[1] && mq1.size() < QD;
        p2 = iv[2] && mq2.size() < QD;
        d0 = id0;
        d1 = id1;
        d2 = id2;
        t = cfg;
        @(posedge clk);
        if (d) void'(mp.pop_front());
        if (f) begin
            void'(mq0.pop_front());
            void'(mq1.pop_front());
            void'(mq2.pop_front());
            mp.push_back(t);
        end
        if (p0) mq0.push_back(d0);
        if (p1) mq1.push_back(d1);
        if (p2) mq2.push_back(d2);
        @(negedge clk);
    endtask

    task automatic tick_b();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        iv = '0;
        mdv = 1'b0;
        bv = '0;
        bmdv = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv = 3'b111;
        o0r = 1'b1; o1r = 1'b1; o2r = 1'b1; mdv = 1'b1;
        #1;
        n_cmp++; if ({o0v, o1v, o2v} !== 3'b000) begin n_bad++; $display("FAIL reset_valids: got %b want 000", {o0v, o1v, o2v}); end
        n_cmp++; if (ir !== 3'b111) begin n_bad++; $display("FAIL reset_ready: got %b want 111", ir); end
        n_cmp++; if (mdr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_done_ready: got %b want 0", mdr); end
        n_cmp++; if (err !== 1'b0 || berr !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b/%b want 0/0", err, berr); end
        do_reset();
    endtask

    task automatic test_basic();
        cfg = 4'hA;
        o0r = 1'b1; o1r = 1'b1; o2r = 1'b1; mdv = 1'b0;
        id0 = {4'h5, 32'h100}; id1 = {4'h6, 32'hDEAD}; id2 = {4'h7, 32'h0};
        iv = 3'b111;
        #1;
        n_cmp++; if ({o0v, o1v} !== 2'b00) begin n_bad++; $display("FAIL basic_no_passthrough: got %b want 00", {o0v, o1v}); end
        step_a();
        iv = '0;
        #1;
        n_cmp++; if ({o0v, o1v} !== 2'b11) begin n_bad++; $display("FAIL basic_valids: got %b want 11", {o0v, o1v}); end
        n_cmp++; if (o0d !== {4'hA, 32'h100}) begin n_bad++; $display("FAIL basic_out0_data: got %h want a00000100", o0d); end
        n_cmp++; if (o1d !== {4'hA, 32'hDEAD}) begin n_bad++; $display("FAIL basic_out1_data: got %h want a0000dead", o1d); end
        step_a();
        mdv = 1'b1;
        #1;
        n_cmp++; if ({o2v, mdr} !== 2'b11) begin n_bad++; $display("FAIL basic_done_hs: got %b want 11", {o2v, mdr}); end
        n_cmp++; if (o2d !== 4'hA) begin n_bad++; $display("FAIL basic_done_tag: got %h want a", o2d); end
        step_a();
        #1;
        n_cmp++; if ({o2v, mdr} !== 2'b00) begin n_bad++; $display("FAIL basic_count_zero: got %b want 00", {o2v, mdr}); end
        mdv = 1'b0;
    endtask

    task automatic test_backpressure();
        cfg = 4'h4;
        o0r = 1'b1; o1r = 1'b0; o2r = 1'b1; mdv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            id0 = {4'h1, 32'h200 + 32'(i)}; id1 = {4'h2, 32'h300 + 32'(i)}; id2 = '0;
            iv = 3'b111;
            #1;
            n_cmp++; if (o0v !== 1'b0) begin n_bad++; $display("FAIL bp_out0_valid[%0d]: got %b want 0", i, o0v); end
            n_cmp++; if (ir !== ((i < QD) ? 3'b111 : 3'b000)) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want %b", i, ir, (i < QD) ? 3'b111 : 3'b000); end
            step_a();
        end
        iv = '0;
        #1;
        n_cmp++; if (o1v !== 1'b1) begin n_bad++; $display("FAIL bp_out1_valid: got %b want 1", o1v); end
        o1r = 1'b1; mdv = 1'b1;
        for (int i = 0; i < QD; i++) begin
            #1;
            n_cmp++; if (o0v !== 1'b1 || o0d !== {4'h4, 32'h200 + 32'(i)} || o1d !== {4'h4, 32'h300 + 32'(i)})
                begin n_bad++; $display("FAIL bp_release[%0d]: got %b %h %h want 1 %h %h", i, o0v, o0d, o1d, {4'h4, 32'h200 + 32'(i)}, {4'h4, 32'h300 + 32'(i)}); end
            step_a();
        end
        #1;
        n_cmp++; if ({o0v, o2v} !== 2'b01) begin n_bad++; $display("FAIL bp_drained: got %b want 01", {o0v, o2v}); end
        step_a();
        mdv = 1'b0;
    endtask

    task automatic test_max_outstanding();
        o0r = 1'b1; o1r = 1'b0; o2r = 1'b1; mdv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id0 = {4'h0, 32'h400 + 32'(i)}; id1 = {4'h0, 32'h500 + 32'(i)}; id2 = '0;
            iv = 3'b111;
            step_a();
        end
        iv = '0; o1r = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cfg = 4'(i + 1);
            #1;
            n_cmp++; if (o0v !== 1'b1 || o0d !== {4'(i + 1), 32'h400 + 32'(i)}) begin n_bad++; $display("FAIL mo_issue[%0d]: got %b %h", i, o0v, o0d); end
            step_a();
        end
        cfg = 4'h3;
        #1;
        n_cmp++; if ({o0v, o1v} !== 2'b00) begin n_bad++; $display("FAIL mo_stall: got %b want 00", {o0v, o1v}); end
        step_a();
        mdv = 1'b1;
        #1;
        n_cmp++; if (o0v !== 1'b0 || mdr !== 1'b1 || o2d !== 4'h1) begin n_bad++; $display("FAIL mo_ack: got %b %b %h want 0 1 1", o0v, mdr, o2d); end
        step_a();
        mdv = 1'b0;
        #1;
        n_cmp++; if (o0v !== 1'b1 || o0d !== {4'h3, 32'h402}) begin n_bad++; $display("FAIL mo_third: got %b %h want 1 300000402", o0v, o0d); end
        step_a();
        mdv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (mdr !== 1'b1 || o2d !== 4'(i + 2)) begin n_bad++; $display("FAIL mo_drain[%0d]: got %b %h want 1 %h", i, mdr, o2d, 4'(i + 2)); end
            step_a();
        end
        #1;
        n_cmp++; if (mdr !== 1'b0) begin n_bad++; $display("FAIL mo_empty: got %b want 0", mdr); end
        mdv = 1'b0;
    endtask

    task automatic test_fire_and_ack();
        o0r = 1'b1; o1r = 1'b1; o2r = 1'b1; mdv = 1'b0;
        cfg = 4'hC;
        id0 = {4'h0, 32'h600}; id1 = {4'h0, 32'h700}; id2 = '0;
        iv = 3'b111;
        step_a();
        iv = '0;
        step_a();
        cfg = 4'hD;
        id0 = {4'h0, 32'h601}; id1 = {4'h0, 32'h701};
        iv = 3'b111;
        step_a();
        iv = '0; mdv = 1'b1;
        #1;
        n_cmp++; if ({o0v, o2v, mdr} !== 3'b111 || o2d !== 4'hC) begin n_bad++; $display("FAIL fa_same_cycle: got %b %h want 111 c", {o0v, o2v, mdr}, o2d); end
        step_a();
        #1;
        n_cmp++; if ({o0v, mdr} !== 2'b01 || o2d !== 4'hD) begin n_bad++; $display("FAIL fa_count_kept: got %b %h want 01 d", {o0v, mdr}, o2d); end
        step_a();
        #1;
        n_cmp++; if (mdr !== 1'b0) begin n_bad++; $display("FAIL fa_empty: got %b want 0", mdr); end
        mdv = 1'b0;
    endtask

    task automatic test_random();
        bit e;
        for (int c = 0; c < 400; c++) begin
            iv = 3'($urandom);
            id0 = {4'($urandom), $urandom}; id1 = {4'($urandom), $urandom}; id2 = {4'($urandom), $urandom};
            o0r = $urandom_range(0, 3) != 0;
            o1r = $urandom_range(0, 3) != 0;
            o2r = $urandom_range(0, 1) != 0;
            mdv = $urandom_range(0, 2) == 0;
            cfg = 4'($urandom);
            #1;
            e = m_issue();
            n_cmp++; if (ir !== m_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, ir, m_ready()); end
            n_cmp++; if ({o0v, o1v} !== {e && o1r, e && o0r}) begin n_bad++; $display("FAIL rnd_valids[%0d]: got %b want %b", c, {o0v, o1v}, {e && o1r, e && o0r}); end
            if (e) begin
                n_cmp++; if (o0d !== {cfg, mq0[0][31:0]} || o1d !== {cfg, mq1[0][31:0]})
                    begin n_bad++; $display("FAIL rnd_data[%0d]: got %h %h want %h %h", c, o0d, o1d, {cfg, mq0[0][31:0]}, {cfg, mq1[0][31:0]}); end
            end
            n_cmp++; if ({o2v, mdr} !== {mdv && mp.size() > 0, o2r && mp.size() > 0}) begin n_bad++; $display("FAIL rnd_done[%0d]: got %b pending %0d", c, {o2v, mdr}, mp.size()); end
            if (mp.size() > 0) begin
                n_cmp++; if (o2d !== mp[0]) begin n_bad++; $display("FAIL rnd_done_tag[%0d]: got %h want %h", c, o2d, mp[0]); end
            end
            step_a();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        o0r = 1'b1; o1r = 1'b1; o2r = 1'b1; mdv = 1'b0; cfg = 4'h9;
        for (int i = 0; i < 5; i++) begin
            id0 = {4'h0, 32'h800 + 32'(i)}; id1 = {4'h0, 32'h900 + 32'(i)}; id2 = '0;
            iv = 3'b111;
            step_a();
        end
        iv = '0; mdv = 1'b1;
        #1;
        n_cmp++; if ({o0v, o2v, mdr} !== 3'b011 || mq0.size() != 3) begin n_bad++; $display("FAIL rm_before: got %b queued %0d want 011 3", {o0v, o2v, mdr}, mq0.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({o0v, o1v, o2v, mdr} !== 4'b0000) begin n_bad++; $display("FAIL rm_async: got %b want 0000", {o0v, o1v, o2v, mdr}); end
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({o2v, mdr} !== 2'b00 || ir !== 3'b111) begin n_bad++; $display("FAIL rm_spurious_ack: got %b %b want 00 111", {o2v, mdr}, ir); end
        step_a();
        #1;
        n_cmp++; if ({o0v, o2v, mdr} !== 3'b000) begin n_bad++; $display("FAIL rm_after: got %b want 000", {o0v, o2v, mdr}); end
        mdv = 1'b0;
    endtask

    task automatic test_transparent();
        b0r = 1'b1; b1r = 1'b1; b2r = 1'b1; bmdv = 1'b0;
        bd0 = {4'h7, 32'hA500}; bd1 = {4'h7, 32'hA600}; bd2 = {32'h1234_5678, 4'h7};
        bv = 3'b111;
        tick_b();
        bv = '0;
        #1;
        n_cmp++; if ({b0v, b1v} !== 2'b11 || b0d !== {4'h7, 32'hA500} || b1d !== {4'h7, 32'hA600})
            begin n_bad++; $display("FAIL tr_match: got %b %h %h", {b0v, b1v}, b0d, b1d); end
        tick_b();
        bmdv = 1'b1;
        #1;
        n_cmp++; if (b2v !== 1'b1 || b2d !== 4'h7) begin n_bad++; $display("FAIL tr_done_tag: got %b %h want 1 7", b2v, b2d); end
        tick_b();
        bmdv = 1'b0;
        bd0 = {4'h3, 32'hB500}; bd1 = {4'h3, 32'hB600}; bd2 = {32'hABCD_0123, 4'h5};
        bv = 3'b111;
        tick_b();
        #1;
        n_cmp++; if ({b0v, b1v, berr} !== 3'b000) begin n_bad++; $display("FAIL tr_mismatch_stall: got %b want 000", {b0v, b1v, berr}); end
        for (int i = 0; i < 3; i++) tick_b();
        bv = '0;
        #1;
        n_cmp++; if (br !== 3'b000 || berr !== 1'b0) begin n_bad++; $display("FAIL tr_full: got %b %b want 000 0", br, berr); end
        tick_b();
        #1;
        n_cmp++; if (berr !== 1'b1 || b0v !== 1'b0) begin n_bad++; $display("FAIL tr_err_set: got %b %b want 1 0", berr, b0v); end
        for (int i = 0; i < 3; i++) tick_b();
        #1;
        n_cmp++; if (berr !== 1'b1) begin n_bad++; $display("FAIL tr_err_sticky: got %b want 1", berr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (berr !== 1'b0 || br !== 3'b111) begin n_bad++; $display("FAIL tr_err_reset: got %b %b want 0 111", berr, br); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        iv = '0; id0 = '0; id1 = '0; id2 = '0; o0r = 1'b0; o1r = 1'b0; o2r = 1'b0; mdv = 1'b0; cfg = '0;
        bv = '0; bd0 = '0; bd1 = '0; bd2 = '0; b0r = 1'b0; b1r = 1'b0; b2r = 1'b0; bmdv = 1'b0; bcfg = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_max_outstanding();
        test_fire_and_ack();
        test_random();
        test_reset_mid();
        test_transparent();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
